// File: rtl/legv8_instr_encoder.sv
// Assembles LEGv8 instruction words (LDUR/STUR/CBZ/ADD/SUB/AND/ORR) from decoded fields
// and buffers them in a small FIFO; illegal requests are consumed, dropped and counted.
module legv8_instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_kind,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rn,
  input  logic [4:0]       in_rm,
  input  logic [18:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err_pulse,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] err_count
);

  // Handshake: a transfer happens at a rising edge where valid && ready are both 1;
  // valid never waits on ready, and ready is registered-state only (no comb path).
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   occ;
  logic             ready_en;
  logic [31:0]      last_q;
  logic [31:0]      enc_word;
  logic             enc_legal;
  logic             accept, push, pop;
  logic             imm_fits_d;

  // D-format offsets are 9-bit signed: the upper bits must be pure sign extension.
  assign imm_fits_d = (&in_imm[18:8]) || !(|in_imm[18:8]);

  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b1;
    case (in_kind)
      3'd0: begin
        enc_word  = {OP_LDUR, in_imm[8:0], 2'b00, in_rn, in_rd};
        enc_legal = imm_fits_d;
      end
      3'd1: begin
        enc_word  = {OP_STUR, in_imm[8:0], 2'b00, in_rn, in_rd};
        enc_legal = imm_fits_d;
      end
      3'd2: enc_word = {OP_CBZ, in_imm, in_rd};
      3'd3: enc_word = {OP_ADD, in_rm, 6'd0, in_rn, in_rd};
      3'd4: enc_word = {OP_SUB, in_rm, 6'd0, in_rn, in_rd};
      3'd5: enc_word = {OP_AND, in_rm, 6'd0, in_rn, in_rd};
      3'd6: enc_word = {OP_ORR, in_rm, 6'd0, in_rn, in_rd};
      default: enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = ready_en && (occ < DEPTH_L);
  assign out_valid = (occ != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_legal;
  assign pop       = out_valid && out_ready;
  // When empty the last popped word stays on the output.
  assign out_instr = out_valid ? mem[rd_ptr] : last_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en    <= 1'b0;
      occ         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_q      <= 32'd0;
      err_pulse   <= 1'b0;
      instr_count <= '0;
      err_count   <= '0;
    end else begin
      ready_en  <= 1'b1;
      err_pulse <= accept && !enc_legal;
      if (accept && !enc_legal && (err_count != '1)) err_count <= err_count + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        last_q      <= mem[rd_ptr];
        instr_count <= instr_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
